// File: rtl/apb_rr_master_pkg.sv
// Shared types and defaults for the round-robin APB master.
// Holds the bus-phase enum, default widths and the pointer-width helper.
package apb_rr_master_pkg;

  localparam int unsigned NREQ_DEF       = 32'd2;
  localparam int unsigned AWIDTH_DEF     = 32'd8;
  localparam int unsigned DWIDTH_DEF     = 32'd8;
  localparam int unsigned TMO_CYCLES_DEF = 32'd16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Width of an index into NREQ requesters; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo NREQ. Returns a one-hot grant and the matching index.
module apb_rr_arbiter
  import apb_rr_master_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);

  logic [PW-1:0] cand_s;
  logic          hit_s;
  logic          found_s;

  // Scan requesters in priority order starting from the pointer.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand_s        = PW'((int'(ptr_i) + i) % int'(NREQ));
      hit_s         = ~found_s & req_i[cand_s];
      gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
      idx_o         = hit_s ? cand_s : idx_o;
      found_s       = found_s | hit_s;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ requesters with round-robin arbitration.
// Optional PREADY timeout enabled by defining APB_RR_MASTER_TIMEOUT_EN.
module apb_rr_master
  import apb_rr_master_pkg::*;
#(
  parameter int unsigned NREQ       = NREQ_DEF,
  parameter int unsigned AWIDTH     = AWIDTH_DEF,
  parameter int unsigned DWIDTH     = DWIDTH_DEF,
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic                     PCLK,
  input  logic                     PRESETN,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          REQ_WRITE,
  input  logic [NREQ*AWIDTH-1:0]   REQ_ADDR,
  input  logic [NREQ*DWIDTH-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]          ACK,
  output logic [DWIDTH-1:0]        RDATA,
  output logic                     ERR,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AWIDTH-1:0]        PADDR,
  output logic [DWIDTH-1:0]        PWDATA,
  input  logic [DWIDTH-1:0]        PRDATA,
  input  logic                     PREADY
);

  localparam int unsigned PW = ptr_width(NREQ);

  if ((NREQ < 32'd2) || (NREQ > 32'd8) || (TMO_CYCLES < 32'd1)) begin : g_bad_param
    $error("apb_rr_master: unsupported parameter set");
  end

  apb_state_e          state_q;
  logic [PW-1:0]       ptr_q;
  logic [NREQ-1:0]     gnt_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [AWIDTH-1:0]   paddr_q;
  logic [DWIDTH-1:0]   pwdata_q;
  logic [NREQ-1:0]     ack_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic                err_q;

  logic [NREQ-1:0]     arb_req_s;
  logic [NREQ-1:0]     arb_gnt_s;
  logic [PW-1:0]       arb_idx_s;
  logic                arb_valid_s;
  logic [PW-1:0]       ptr_d;

`ifdef APB_RR_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYCLES + 32'd1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 32'd1);
  logic [TW-1:0] tmo_cnt_q;
`endif

  // A requester whose ACK is high this cycle is already served.
  assign arb_req_s   = REQ & ~ack_q;
  assign arb_valid_s = |arb_gnt_s;
  assign ptr_d       = (arb_idx_s == PW'(NREQ - 32'd1)) ? '0 : arb_idx_s + 1'b1;

  apb_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i (arb_req_s),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s)
  );

  // Bus-phase sequencer: arbitrate in IDLE, drive SETUP, wait out ACCESS.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_RR_MASTER_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          penable_q <= 1'b0;
          if (arb_valid_s) begin
            gnt_q    <= arb_gnt_s;
            ptr_q    <= ptr_d;
            paddr_q  <= REQ_ADDR[int'(arb_idx_s)*int'(AWIDTH) +: AWIDTH];
            pwdata_q <= REQ_WDATA[int'(arb_idx_s)*int'(DWIDTH) +: DWIDTH];
            pwrite_q <= REQ_WRITE[arb_idx_s];
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end else begin
            psel_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_RR_MASTER_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= gnt_q;
            state_q   <= IDLE;
            if (!pwrite_q) begin
              rdata_q <= PRDATA;
            end else begin
              rdata_q <= rdata_q;
            end
          end
`ifdef APB_RR_MASTER_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            // Slave never answered: release the bus and flag the requester.
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= gnt_q;
            err_q     <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            state_q   <= ACCESS;
          end
`else
          else begin
            state_q <= ACCESS;
          end
`endif
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ACK     = ack_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_apb_rr_master;

  localparam int unsigned N   = 2;
  localparam int unsigned A   = 8;
  localparam int unsigned D   = 8;
  localparam int unsigned TMO = 16;

  logic           PCLK = 1'b0;
  logic           PRESETN;
  logic [N-1:0]   REQ, REQ_WRITE;
  logic [N*A-1:0] REQ_ADDR;
  logic [N*D-1:0] REQ_WDATA;
  logic [N-1:0]   ACK;
  logic [D-1:0]   RDATA, PWDATA, PRDATA;
  logic [A-1:0]   PADDR;
  logic           ERR, PSEL, PENABLE, PWRITE, PREADY;

  int n_tests = 0;
  int n_fail  = 0;

  apb_rr_master #(.NREQ(N), .AWIDTH(A), .DWIDTH(D), .TMO_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .RDATA(RDATA),
    .ERR(ERR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: one outstanding transfer, its phase, and RR pointer.
  int           m_ptr, m_g, m_wait;
  bit           m_busy, m_acc;
  logic [A-1:0] m_addr;
  logic [D-1:0] m_wdata, m_rdata;
  logic         m_wr, m_err;
  logic [N-1:0] m_ack;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] elig);
    for (int k = 0; k < int'(N); k++) begin
      int c = (ptr + k) % int'(N);
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_g = 0; m_wait = 0; m_busy = 1'b0; m_acc = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_wr = 1'b0; m_err = 1'b0; m_ack = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] ack_prev;
    int g;
    if (!PRESETN) begin
      model_reset();
      return;
    end
    ack_prev = m_ack;
    m_ack = '0;
    m_err = 1'b0;
    if (!m_busy) begin
      g = rr_pick(m_ptr, REQ & ~ack_prev);
      if (g >= 0) begin
        m_g = g; m_ptr = (g + 1) % int'(N);
        m_busy = 1'b1; m_acc = 1'b0;
        m_addr = REQ_ADDR[g*A +: A]; m_wdata = REQ_WDATA[g*D +: D]; m_wr = REQ_WRITE[g];
      end
    end else if (!m_acc) begin
      m_acc = 1'b1; m_wait = 0;
    end else if (PREADY) begin
      m_busy = 1'b0; m_acc = 1'b0; m_ack[m_g] = 1'b1;
      if (!m_wr) m_rdata = PRDATA;
    end else begin
      m_wait++;
`ifdef APB_RR_MASTER_TIMEOUT_EN
      if (m_wait >= int'(TMO)) begin
        m_busy = 1'b0; m_acc = 1'b0; m_ack[m_g] = 1'b1; m_err = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_outputs();
    check_val("psel",    32'(PSEL),    32'(m_busy));
    check_val("penable", 32'(PENABLE), 32'(m_busy && m_acc));
    check_val("ack",     32'(ACK),     32'(m_ack));
    check_val("err",     32'(ERR),     32'(m_err));
    check_val("rdata",   32'(RDATA),   32'(m_rdata));
    if (m_busy || !PRESETN) begin
      check_val("paddr",  32'(PADDR),  32'(m_addr));
      check_val("pwdata", 32'(PWDATA), 32'(m_wdata));
      check_val("pwrite", 32'(PWRITE), 32'(m_wr));
    end
  endtask

  task automatic cycle();
    @(posedge PCLK);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int i, input logic wr, input logic [A-1:0] addr, input logic [D-1:0] wd);
    REQ[i] = 1'b1; REQ_WRITE[i] = wr; REQ_ADDR[i*A +: A] = addr; REQ_WDATA[i*D +: D] = wd;
  endtask

  task automatic retire_acked();
    for (int i = 0; i < int'(N); i++) if (m_ack[i]) REQ[i] = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    bit done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      cycle();
      retire_acked();
      done = (REQ == '0) && !m_busy;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Holds PREADY low for nwait ACCESS cycles, then completes the transfer.
  task automatic stall_until_idle(input string tag, input int nwait, input int bound,
                                  input logic [D-1:0] rd);
    bit done = 1'b0;
    int acc = 0;
    PREADY = 1'b0;
    PRDATA = ~rd;
    for (int k = 0; k < bound && !done; k++) begin
      cycle();
      retire_acked();
      if (m_busy && m_acc) begin
        PREADY = (acc >= nwait);
        acc++;
      end else begin
        PREADY = 1'b0;
      end
      PRDATA = PREADY ? rd : ~rd;
      done = (REQ == '0) && !m_busy;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic drive_random();
    for (int i = 0; i < int'(N); i++) begin
      if (m_ack[i]) begin
        if ($urandom_range(0, 1) == 0) REQ[i] = 1'b0;
        else set_req(i, 1'($urandom_range(0, 1)), A'($urandom), D'($urandom));
      end else if (!REQ[i] && $urandom_range(0, 3) == 0) begin
        set_req(i, 1'($urandom_range(0, 1)), A'($urandom), D'($urandom));
      end
    end
    PREADY = ($urandom_range(0, 3) != 0);
    PRDATA = D'($urandom);
  endtask

  initial begin
    bit reached;
    PRESETN = 1'b0; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    PREADY = 1'b0; PRDATA = '0;
    model_reset();
    repeat (2) cycle();
    #2 PRESETN = 1'b1;
    cycle();

    // Single write from requester 0, zero wait states.
    set_req(0, 1'b1, 8'h12, 8'hA5); PREADY = 1'b1; PRDATA = 8'h3C;
    run_until_idle("wr0", 10);

    // Single read from requester 1.
    set_req(1, 1'b0, 8'h12, 8'h00); PRDATA = 8'hA5;
    run_until_idle("rd1", 10);

    // Both requesting continuously: alternating grants every 3 cycles.
    set_req(0, 1'b1, 8'h20, 8'h11); set_req(1, 1'b0, 8'h21, 8'h00); PRDATA = 8'h77;
    repeat (12) cycle();
    run_until_idle("rr", 12);

    // Four wait states, then a slave stuck low for 20 ACCESS cycles.
    set_req(0, 1'b0, 8'h30, 8'h00);
    stall_until_idle("wait4", 4, 20, 8'hC3);
    set_req(0, 1'b1, 8'h40, 8'h5A);
    stall_until_idle("stuck", 20, 40, 8'h66);

    // Asynchronous reset in the middle of ACCESS, then re-serve the request.
    set_req(1, 1'b0, 8'h34, 8'h00); PREADY = 1'b0; PRDATA = 8'h81;
    reached = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      cycle();
      reached = m_busy && m_acc;
    end
    check_val("reach_access", 32'(reached), 32'd1);
    #2 PRESETN = 1'b0;
    #1;
    check_val("async_psel",    32'(PSEL),    32'd0);
    check_val("async_penable", 32'(PENABLE), 32'd0);
    check_val("async_ack",     32'(ACK),     32'd0);
    model_reset();
    repeat (2) cycle();
    #2 PRESETN = 1'b1;
    PREADY = 1'b1; PRDATA = 8'h9E;
    run_until_idle("rst_reserve", 10);

    // Random traffic with random wait states.
    repeat (400) begin
      drive_random();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Multi-requester APB master that shares one APB slave bus between NREQ local requesters using round-robin arbitration.
- Sequences the APB setup/access phases and inserts wait states on PREADY.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Sits between CPU-side command sources and the APB slave fabric.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AWIDTH, 8, APB address width
- DWIDTH, 8, APB data width
- TMO_CYCLES, 16, PREADY timeout limit in ACCESS cycles (used only with the optional feature)

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETN  in  1  asynchronous active-low reset
- REQ  in  NREQ  per-requester transfer request, held until its ACK
- REQ_WRITE  in  NREQ  per-requester direction, 1 = write
- REQ_ADDR  in  NREQ*AWIDTH  packed addresses; requester i in bits [i*AWIDTH +: AWIDTH]
- REQ_WDATA  in  NREQ*DWIDTH  packed write data, same packing
- ACK  out  NREQ  one-hot, one-cycle completion pulse
- RDATA  out  DWIDTH  read data of last completed read, valid with ACK
- ERR  out  1  transfer error flag, valid with ACK
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  AWIDTH  APB address
- PWDATA  out  DWIDTH  APB write data
- PRDATA  in  DWIDTH  APB read data
- PREADY  in  1  APB ready

Behaviour:
- Clock and reset: one clock, PCLK; reset is asynchronous and active-low, PRESETN.
- Reset values: state = IDLE; PSEL, PENABLE, PWRITE, ACK, ERR = 0; PADDR, PWDATA, RDATA = 0; RR pointer = 0.
- States are IDLE, SETUP and ACCESS.
- IDLE:
  - Arbitrate over REQ & ~ACK. The mask drops a requester in the same cycle its ACK is high.
  - If any request is eligible:
    - Latch the winner index g, plus REQ_ADDR[g], REQ_WDATA[g] and REQ_WRITE[g], into PADDR/PWDATA/PWRITE.
    - Set PSEL = 1 and go to SETUP.
  - Otherwise PSEL = 0.
- SETUP: PSEL = 1, PENABLE = 0, drive the latched values. Next cycle set PENABLE = 1 and go to ACCESS.
- ACCESS:
  - PADDR, PWRITE, PWDATA and PSEL are held stable.
  - While PREADY = 0, stay in ACCESS (wait state).
  - When PREADY = 1:
    - Next cycle: PSEL = 0, PENABLE = 0, ACK[g] = 1 for exactly one cycle.
    - If the transfer was a read, RDATA = PRDATA sampled on that edge.
    - Go to IDLE.
- One mandatory IDLE cycle between transfers, so PSEL is never asserted for more than two cycles at zero wait states.
- Back-to-back throughput is 1 transfer per 3 cycles.
- Latency: REQ high in IDLE -> PSEL next edge -> PENABLE +1 -> ACK one cycle after the PREADY=1 edge. Minimum 3 cycles, REQ to ACK.
- Round-robin:
  - Search starts at pointer p and wraps modulo NREQ.
  - On grant of g, p = (g+1) mod NREQ, so index NREQ-1 wraps to 0.
  - No requests means no grant and p unchanged.
- Requester rules:
  - Hold REQ and its fields until ACK.
  - Deasserting REQ before ACK is illegal. The transfer is already latched and completes anyway.
- RDATA holds its value until the next completed read; writes do not alter it.
- ERR = 0 always, unless the optional feature is enabled.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous). No ACK is issued for the aborted transfer.

Optional Feature:
- Macro: APB_RR_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS, cleared on SETUP->ACCESS entry.
  - If PREADY is still 0 after TMO_CYCLES ACCESS cycles, the transfer is abandoned.
  - ACK[g] = 1 and ERR = 1 in the same cycle; RDATA is unchanged; go to IDLE.
  - Counter width is clog2(TMO_CYCLES+1).
- Undefined: no counter; ACCESS waits indefinitely; ERR tied 0.

Decomposition:
- Package apb_rr_master_pkg holds:
  - the state enum {IDLE, SETUP, ACCESS}
  - a function computing the pointer index width, clog2(NREQ)
  - the default width constants
- One sub-module, apb_rr_arbiter: combinational round-robin pick from a request vector and pointer, giving a one-hot grant plus an index. Pointer register stays in the top.

Test Plan:
- Requester 0 write, addr 0x12, data 0xA5, PREADY=1 -> PSEL 2 cycles, PENABLE 1 cycle, PADDR=0x12, PWDATA=0xA5, ACK=2'b01 one cycle later.
- Requester 1 read, addr 0x12, slave returns 0xA5 -> RDATA=0xA5 with ACK=2'b10, ERR=0.
- REQ=2'b11 continuously, pointer=0 -> grant order 0,1,0,1; transfers spaced 3 cycles apart; no PSEL high for more than 2 consecutive cycles.
- PREADY held low 4 cycles in ACCESS -> PADDR/PWDATA/PSEL stable for all wait cycles; ACK follows the first PREADY=1 edge.
- With macro defined, TMO_CYCLES=16, PREADY stuck 0 -> ACK plus ERR=1 after 16 ACCESS cycles, RDATA unchanged, next request served normally.
- PRESETN low during ACCESS -> PSEL/PENABLE/ACK drop asynchronously to 0; after release, state is IDLE, pointer is 0, and the pending REQ is re-served from SETUP.
